cic_3_interp_filter: RTL

//  3rd-order CIC interpolator (N=3, differential delay 1), upsampling by M.

---
 rtl/cic_3_interp_filter.sv | 118 +++++++++++
 1 files changed

// File: rtl/cic_3_interp_filter.sv
// rtl/cic_3_interp_filter.sv - 3rd-order CIC interpolator, upsampling by M, valid/ready sample input.
// Optional build macro: CIC_INTERP_UNDERRUN_HOLD_EN (underrun slot repeats last accepted sample).
module cic_3_interp_filter #(
  parameter int M     = 10,
  parameter int width = 11
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic signed [width-1:0]               in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [width+$clog2(M**3)-1:0]  out,
  output logic                                  out_valid,
  output logic                                  underrun
);

  localparam int OW = width + $clog2(M**3);
  localparam int PW = (M > 2) ? $clog2(M) : 1;

  logic                   started;
  logic [PW-1:0]          phase;
  logic                   phase_zero;
  logic                   phase_last;
  logic                   accept;
  logic                   slot_miss;

  // sample_q/slot_q decouple the handshake from the comb section by one cycle
  logic signed [width-1:0] sample_q;
  logic                    slot_q;

  logic signed [width-1:0] x1_d;
  logic signed [width:0]   x2_d;
  logic signed [width+1:0] x3_d;
  logic signed [width:0]   y1;
  logic signed [width+1:0] y2;
  logic signed [width+2:0] y3;

  logic signed [OW-1:0]    u;
  logic signed [OW-1:0]    i1;
  logic signed [OW-1:0]    i2;
  logic signed [OW-1:0]    i3;

  assign phase_zero = (phase == '0);
  assign phase_last = (phase == PW'(M - 1));
  assign in_ready   = !started || phase_zero;
  assign accept     = in_valid && in_ready;
  assign slot_miss  = started && phase_zero && !in_valid;

  // Each comb grows by one bit so the difference never overflows
  always_comb begin
    y1 = {sample_q[width-1], sample_q} - {x1_d[width-1], x1_d};
    y2 = {y1[width], y1} - {x2_d[width], x2_d};
    y3 = {y2[width+1], y2} - {x3_d[width+1], x3_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started   <= 1'b0;
      phase     <= '0;
      sample_q  <= '0;
      slot_q    <= 1'b0;
      underrun  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept && !started) begin
        started <= 1'b1;
      end
      if (started || accept) begin
        phase <= (started && phase_last) ? '0 : phase + PW'(1);
      end
      if (accept) begin
        sample_q <= in;
      end else if (slot_miss) begin
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
        sample_q <= sample_q;
`else
        sample_q <= '0;
`endif
      end
      slot_q    <= accept || slot_miss;
      underrun  <= underrun || slot_miss;
      out_valid <= out_valid || accept;
    end
  end

  // Combs run at the slot rate; u carries the zero-stuffed comb output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_d <= '0;
      x2_d <= '0;
      x3_d <= '0;
      u    <= '0;
    end else if (slot_q) begin
      x1_d <= sample_q;
      x2_d <= y1;
      x3_d <= y2;
      u    <= OW'(y3);
    end else begin
      u    <= '0;
    end
  end

  // Integrators wrap freely; the final value is exact modulo 2**OW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + u;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  assign out = i3;

endmodule
